// File: rtl/interrupt_sequencer.sv
// Vectored, nestable interrupt sequencer: edge-captured IRQ lines, fixed priority
// (line 0 highest), per-line vectors, an internal EPC stack popped by uret.
module interrupt_sequencer #(
  parameter int unsigned          NUM_IRQ    = 3,
  parameter int unsigned          PC_W       = 32,
  parameter logic [PC_W-1:0]      VEC_BASE   = 32'h0000_1000,
  parameter logic [PC_W-1:0]      VEC_STRIDE = 32'h0000_0100,
  parameter logic [NUM_IRQ-1:0]   IE_RST     = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               instr_valid,
  input  logic [PC_W-1:0]    pc_next,
  input  logic               uret,
  input  logic               csr_set,
  input  logic               csr_clr,
  input  logic [NUM_IRQ-1:0] csr_imm,
  output logic               take_int,
  output logic [PC_W-1:0]    int_vector,
  output logic               ret,
  output logic [PC_W-1:0]    epc_out,
  output logic [NUM_IRQ-1:0] ie,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service,
  output logic               uret_err
);

  localparam int unsigned SP_W = $clog2(NUM_IRQ + 1);

  logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q, rise;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] ie_q, ie_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] elig, take_mask;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [PC_W-1:0]    stack_q [NUM_IRQ];
  logic               uret_err_q, uret_err_d;
  logic               sp_nz;
  int unsigned        cur, sel;

  assign rise  = s2_q & ~s3_q;
  assign sp_nz = (sp_q != '0);

  always_comb begin
    cur = NUM_IRQ;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (in_service_q[i-1]) cur = i - 1;
    end
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      elig[i] = pending_q[i] & ie_q[i] & (i < cur);
    end
    sel = 0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (elig[i-1]) sel = i - 1;
    end
  end

  // uret pre-empts a take in the same cycle; the take retries on the next retire.
  assign take_int   = instr_valid & (|elig) & ~(uret & sp_nz);
  assign ret        = instr_valid & uret & sp_nz;
  assign int_vector = VEC_BASE + PC_W'(sel) * VEC_STRIDE;

  always_comb begin
    epc_out = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (32'(sp_q) == i + 1) epc_out = stack_q[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      take_mask[i] = take_int && (sel == i);
    end
    // A fresh rise on the line being taken keeps it pending.
    pending_d = (pending_q & ~take_mask) | rise;

    ie_d = ie_q;
    if (csr_clr)      ie_d = ie_q & ~csr_imm;
    else if (csr_set) ie_d = ie_q | csr_imm;

    in_service_d = in_service_q;
    sp_d         = sp_q;
    if (ret) begin
      in_service_d = in_service_q & (in_service_q - NUM_IRQ'(1));
      sp_d         = sp_q - SP_W'(1);
    end else if (take_int) begin
      in_service_d = in_service_q | take_mask;
      sp_d         = sp_q + SP_W'(1);
    end

    uret_err_d = uret_err_q | (instr_valid & uret & ~sp_nz);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      pending_q    <= '0;
      ie_q         <= IE_RST;
      in_service_q <= '0;
      sp_q         <= '0;
      uret_err_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) stack_q[i] <= '0;
    end else begin
      s1_q         <= irq_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      pending_q    <= pending_d;
      ie_q         <= ie_d;
      in_service_q <= in_service_d;
      sp_q         <= sp_d;
      uret_err_q   <= uret_err_d;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        if (take_int && 32'(sp_q) == i) stack_q[i] <= pc_next;
      end
    end
  end

  assign ie         = ie_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign uret_err   = uret_err_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: take/return, nesting, masking,
// uret/take collision, level-held IRQ, empty-stack uret and async reset.
module tb_interrupt_sequencer;

  localparam int unsigned NUM_IRQ = 3;
  localparam int unsigned PC_W    = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq_in;
  logic               instr_valid;
  logic [PC_W-1:0]    pc_next;
  logic               uret, csr_set, csr_clr;
  logic [NUM_IRQ-1:0] csr_imm;
  logic               take_int, ret, uret_err;
  logic [PC_W-1:0]    int_vector, epc_out;
  logic [NUM_IRQ-1:0] ie, pending, in_service;

  int n_cmp = 0;
  int n_err = 0;
  int n_take;

  interrupt_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .instr_valid(instr_valid),
    .pc_next    (pc_next),
    .uret       (uret),
    .csr_set    (csr_set),
    .csr_clr    (csr_clr),
    .csr_imm    (csr_imm),
    .take_int   (take_int),
    .int_vector (int_vector),
    .ret        (ret),
    .epc_out    (epc_out),
    .ie         (ie),
    .pending    (pending),
    .in_service (in_service),
    .uret_err   (uret_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stack depth can never exceed the number of lines.
  always @(negedge clk) begin
    if (rst_n) check_eq("sp_bound", 32'(dut.sp_q <= 2'(NUM_IRQ)), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse, then wait until the request is latched in pending.
  task automatic pulse(input int line);
    irq_in[line] = 1'b1;
    tick();
    irq_in[line] = 1'b0;
    tick();
    tick();
  endtask

  task automatic retire(input logic [PC_W-1:0] pc, input logic do_uret);
    instr_valid = 1'b1;
    pc_next     = pc;
    uret        = do_uret;
    tick();
    instr_valid = 1'b0;
    uret        = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; instr_valid = 1'b0; pc_next = '0;
    uret = 1'b0; csr_set = 1'b0; csr_clr = 1'b0; csr_imm = '0;
    #12;
    check_eq("rst_take", 32'(take_int), 0);
    check_eq("rst_ret", 32'(ret), 0);
    check_eq("rst_epc", epc_out, 0);
    check_eq("rst_vec", int_vector, 32'h1000);
    check_eq("rst_ie", 32'(ie), 3'b111);
    check_eq("rst_pend", 32'(pending), 0);
    check_eq("rst_insvc", 32'(in_service), 0);
    check_eq("rst_uerr", 32'(uret_err), 0);
    rst_n = 1'b1;
    tick();

    // 1: single take and return
    pc_next = 32'h40;
    irq_in[1] = 1'b1;
    tick();
    irq_in[1] = 1'b0;
    tick();
    check_eq("t1_pend_early", 32'(pending), 0);
    tick();
    check_eq("t1_pend", 32'(pending), 3'b010);
    check_eq("t1_noiv_take", 32'(take_int), 0);
    instr_valid = 1'b1; #1;
    check_eq("t1_take", 32'(take_int), 1);
    check_eq("t1_vec", int_vector, 32'h1100);
    retire(32'h40, 1'b0);
    check_eq("t1_pend_clr", 32'(pending), 0);
    check_eq("t1_insvc", 32'(in_service), 3'b010);
    check_eq("t1_epc", epc_out, 32'h40);
    instr_valid = 1'b1; uret = 1'b1; #1;
    check_eq("t1_ret", 32'(ret), 1);
    check_eq("t1_ret_epc", epc_out, 32'h40);
    retire(32'h44, 1'b1);
    check_eq("t1_insvc_0", 32'(in_service), 0);
    check_eq("t1_sp0", 32'(dut.sp_q), 0);

    // 2: nesting, lower-priority request held off until both returns
    pulse(1);
    retire(32'h40, 1'b0);
    pulse(0);
    instr_valid = 1'b1; #1;
    check_eq("t2_nest_take", 32'(take_int), 1);
    check_eq("t2_nest_vec", int_vector, 32'h1000);
    retire(32'h1108, 1'b0);
    check_eq("t2_sp2", 32'(dut.sp_q), 2);
    check_eq("t2_insvc", 32'(in_service), 3'b011);
    pulse(2);
    check_eq("t2_pend2", 32'(pending), 3'b100);
    instr_valid = 1'b1; #1;
    check_eq("t2_blocked", 32'(take_int), 0);
    instr_valid = 1'b1; uret = 1'b1; #1;
    check_eq("t2_ret1", 32'(ret), 1);
    check_eq("t2_epc1", epc_out, 32'h1108);
    retire(32'h1004, 1'b1);
    instr_valid = 1'b1; #1;
    check_eq("t2_still_blocked", 32'(take_int), 0);
    uret = 1'b1; #1;
    check_eq("t2_epc2", epc_out, 32'h40);
    retire(32'h1110, 1'b1);
    instr_valid = 1'b1; #1;
    check_eq("t2_late_take", 32'(take_int), 1);
    check_eq("t2_late_vec", int_vector, 32'h1200);
    retire(32'h40, 1'b0);
    retire(32'h1200, 1'b1);
    check_eq("t2_sp0", 32'(dut.sp_q), 0);

    // 3: masking holds a request pending until re-enabled
    csr_clr = 1'b1; csr_imm = 3'b001;
    tick();
    csr_clr = 1'b0;
    check_eq("t3_ie_clr", 32'(ie), 3'b110);
    pulse(0);
    check_eq("t3_pend", 32'(pending), 3'b001);
    instr_valid = 1'b1; #1;
    check_eq("t3_masked", 32'(take_int), 0);
    retire(32'h60, 1'b0);
    csr_set = 1'b1; csr_clr = 1'b1; csr_imm = 3'b010;
    tick();
    csr_set = 1'b0; csr_clr = 1'b0;
    check_eq("t3_clr_wins", 32'(ie), 3'b100);
    csr_set = 1'b1; csr_imm = 3'b011;
    tick();
    csr_set = 1'b0;
    check_eq("t3_ie_set", 32'(ie), 3'b111);
    check_eq("t3_pend_kept", 32'(pending), 3'b001);
    instr_valid = 1'b1; #1;
    check_eq("t3_take", 32'(take_int), 1);
    check_eq("t3_vec", int_vector, 32'h1000);
    retire(32'h80, 1'b0);
    retire(32'h1000, 1'b1);

    // 4: uret beats a simultaneous take; the take then pushes the return address
    pulse(2);
    retire(32'h50, 1'b0);
    pulse(0);
    instr_valid = 1'b1; uret = 1'b1; #1;
    check_eq("t4_ret", 32'(ret), 1);
    check_eq("t4_no_take", 32'(take_int), 0);
    check_eq("t4_epc", epc_out, 32'h50);
    retire(32'h1204, 1'b1);
    instr_valid = 1'b1; #1;
    check_eq("t4_take", 32'(take_int), 1);
    check_eq("t4_vec", int_vector, 32'h1000);
    retire(32'h50, 1'b0);
    check_eq("t4_epc_push", epc_out, 32'h50);
    check_eq("t4_insvc", 32'(in_service), 3'b001);
    retire(32'h1000, 1'b1);

    // 5: empty-stack uret and a level held high
    instr_valid = 1'b1; uret = 1'b1; #1;
    check_eq("t5_noret", 32'(ret), 0);
    retire(32'h90, 1'b1);
    check_eq("t5_uerr", 32'(uret_err), 1);
    check_eq("t5_sp0", 32'(dut.sp_q), 0);
    irq_in[2] = 1'b1;
    instr_valid = 1'b1;
    n_take = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (take_int) n_take++;
      tick();
    end
    irq_in[2] = 1'b0;
    instr_valid = 1'b0;
    check_eq("t5_one_take", 32'(n_take), 1);
    check_eq("t5_uerr_sticky", 32'(uret_err), 1);
    retire(32'h1200, 1'b1);
    check_eq("t5_sp_back", 32'(dut.sp_q), 0);

    // 6: asynchronous reset while nested
    pulse(1);
    retire(32'h40, 1'b0);
    pulse(0);
    retire(32'h1108, 1'b0);
    csr_clr = 1'b1; csr_imm = 3'b100;
    tick();
    csr_clr = 1'b0;
    check_eq("t6_sp2", 32'(dut.sp_q), 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_sp0", 32'(dut.sp_q), 0);
    check_eq("t6_insvc", 32'(in_service), 0);
    check_eq("t6_ie", 32'(ie), 3'b111);
    check_eq("t6_uerr", 32'(uret_err), 0);
    check_eq("t6_epc", epc_out, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t6_no_take", 32'(take_int), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
